// File: rtl/seg7_scan_serializer_if.sv
// rtl/seg7_scan_serializer_if.sv - capture inputs and chain/analyser outputs of the 7-seg scan serializer
interface seg7_scan_serializer_if;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        update;
  logic        sclk;
  logic        rclk;
  logic        serial_data;
  logic [15:0] line_data;
  logic [4:0]  s_counter;
  logic [2:0]  line_counter;

  // master: whoever supplies the value to display and watches the pins
  modport master (
    output value, dp, blank, update,
    input  sclk, rclk, serial_data, line_data, s_counter, line_counter
  );

  // slave: the serializer itself
  modport slave (
    input  value, dp, blank, update,
    output sclk, rclk, serial_data, line_data, s_counter, line_counter
  );
endinterface

// File: rtl/seg7_scan_serializer.sv
// rtl/seg7_scan_serializer.sv - scans 8 hex digits into a 74HC595-style chain (sclk/serial_data/rclk)
module seg7_scan_serializer #(
  parameter int HALF_PERIOD    = 256,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input logic                   clk,
  input logic                   rst_n,
  seg7_scan_serializer_if.slave bus
);

  localparam int CW = $clog2(HALF_PERIOD);

  typedef enum logic [2:0] {
    ST_START,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH_HI,
    ST_LATCH_LO
  } state_t;

  // {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Line word {seg, en}; polarity applies to seg only, the digit enable is always active-high
  function automatic logic [15:0] make_word(input logic [31:0] v, input logic [7:0] d,
                                            input logic [7:0] b, input logic [2:0] idx);
    logic [7:0] seg;
    logic [7:0] en;
    if (b[idx]) begin
      seg = 8'h00;
      en  = 8'h00;
    end else begin
      seg = {d[idx], hex7(v[idx*4 +: 4])};
      en  = 8'h01 << idx;
    end
    if (ACTIVE_LOW_SEG) seg = ~seg;
    return {seg, en};
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          sclk_q, sclk_d;
  logic          rclk_q, rclk_d;
  logic          serial_data_q, serial_data_d;
  logic [15:0]   line_data_q, line_data_d;
  logic [4:0]    s_counter_q, s_counter_d;
  logic [2:0]    line_counter_q, line_counter_d;
  logic [31:0]   act_value_q, act_value_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic [7:0]    act_blank_q, act_blank_d;
  logic [31:0]   pnd_value_q, pnd_value_d;
  logic [7:0]    pnd_dp_q, pnd_dp_d;
  logic [7:0]    pnd_blank_q, pnd_blank_d;
  logic          pend_q, pend_d;

  logic          tick;
  logic          load;
  logic [2:0]    load_idx;
  logic [3:0]    s_dec;
  logic [15:0]   word;

  // Next-state: prescaler, scan FSM and the pending/active capture pair
  always_comb begin
    state_d        = state_q;
    sclk_d         = sclk_q;
    rclk_d         = rclk_q;
    serial_data_d  = serial_data_q;
    line_data_d    = line_data_q;
    s_counter_d    = s_counter_q;
    line_counter_d = line_counter_q;
    act_value_d    = act_value_q;
    act_dp_d       = act_dp_q;
    act_blank_d    = act_blank_q;
    pnd_value_d    = pnd_value_q;
    pnd_dp_d       = pnd_dp_q;
    pnd_blank_d    = pnd_blank_q;
    pend_d         = pend_q;
    load           = 1'b0;
    load_idx       = 3'd0;
    s_dec          = s_counter_q[3:0] - 4'd1;
    word           = 16'h0000;

    tick    = (count_q == CW'(HALF_PERIOD - 1));
    count_d = tick ? '0 : count_q + CW'(1);

    if (tick) begin
      case (state_q)
        ST_START: begin
          load     = 1'b1;
          load_idx = 3'd0;
        end
        ST_SHIFT_LO: begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          sclk_d = 1'b0;
          if (s_counter_q != 5'd0) begin
            s_counter_d   = {1'b0, s_dec};
            serial_data_d = line_data_q[s_dec];
            state_d       = ST_SHIFT_LO;
          end else begin
            rclk_d  = 1'b1;
            state_d = ST_LATCH_HI;
          end
        end
        ST_LATCH_HI: begin
          rclk_d  = 1'b0;
          state_d = ST_LATCH_LO;
        end
        ST_LATCH_LO: begin
          load     = 1'b1;
          load_idx = line_counter_q + 3'd1;
        end
        default: state_d = ST_START;
      endcase
    end

    if (bus.update) begin
      pnd_value_d = bus.value;
      pnd_dp_d    = bus.dp;
      pnd_blank_d = bus.blank;
      pend_d      = 1'b1;
    end

    // Active data only changes at the top of a frame so a frame never mixes two values
    if (load && load_idx == 3'd0) begin
      if (bus.update) begin
        act_value_d = bus.value;
        act_dp_d    = bus.dp;
        act_blank_d = bus.blank;
        pend_d      = 1'b0;
      end else if (pend_q) begin
        act_value_d = pnd_value_q;
        act_dp_d    = pnd_dp_q;
        act_blank_d = pnd_blank_q;
        pend_d      = 1'b0;
      end
    end

    if (load) begin
      word           = make_word(act_value_d, act_dp_d, act_blank_d, load_idx);
      line_data_d    = word;
      line_counter_d = load_idx;
      s_counter_d    = 5'd15;
      serial_data_d  = word[15];
      state_d        = ST_SHIFT_LO;
    end
  end

  // All state and pin registers; async reset drops the chain pins low at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_START;
      count_q        <= '0;
      sclk_q         <= 1'b0;
      rclk_q         <= 1'b0;
      serial_data_q  <= 1'b0;
      line_data_q    <= 16'h0000;
      s_counter_q    <= 5'd0;
      line_counter_q <= 3'd0;
      act_value_q    <= 32'h0;
      act_dp_q       <= 8'h00;
      act_blank_q    <= 8'hFF;
      pnd_value_q    <= 32'h0;
      pnd_dp_q       <= 8'h00;
      pnd_blank_q    <= 8'hFF;
      pend_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      sclk_q         <= sclk_d;
      rclk_q         <= rclk_d;
      serial_data_q  <= serial_data_d;
      line_data_q    <= line_data_d;
      s_counter_q    <= s_counter_d;
      line_counter_q <= line_counter_d;
      act_value_q    <= act_value_d;
      act_dp_q       <= act_dp_d;
      act_blank_q    <= act_blank_d;
      pnd_value_q    <= pnd_value_d;
      pnd_dp_q       <= pnd_dp_d;
      pnd_blank_q    <= pnd_blank_d;
      pend_q         <= pend_d;
    end
  end

  assign bus.sclk         = sclk_q;
  assign bus.rclk         = rclk_q;
  assign bus.serial_data  = serial_data_q;
  assign bus.line_data    = line_data_q;
  assign bus.s_counter    = s_counter_q;
  assign bus.line_counter = line_counter_q;

endmodule

// File: tb/tb_seg7_scan_serializer.sv
// tb/tb_seg7_scan_serializer.sv - directed bench for seg7_scan_serializer
module tb_seg7_scan_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  seg7_scan_serializer_if ifa ();
  seg7_scan_serializer_if ifb ();

  seg7_scan_serializer #(.HALF_PERIOD(2), .ACTIVE_LOW_SEG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ifa.slave)
  );
  seg7_scan_serializer #(.HALF_PERIOD(2), .ACTIVE_LOW_SEG(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(ifb.slave)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int overlap = 0;
  logic [15:0] sh_a = 16'h0;
  logic [15:0] sh_b = 16'h0;

  always @(posedge clk) cyc++;
  always @(posedge ifa.sclk) sh_a = {sh_a[14:0], ifa.serial_data};
  always @(posedge ifb.sclk) sh_b = {sh_b[14:0], ifb.serial_data};
  always @(negedge clk) begin
    if ((ifa.sclk === 1'b1 && ifa.rclk === 1'b1) || (ifb.sclk === 1'b1 && ifb.rclk === 1'b1))
      overlap++;
  end

  // Waits for the next rclk rise; returns the serially captured word
  task automatic wait_latch(input bit sel_b, output logic [15:0] word, output logic [15:0] ld,
                            output logic [2:0] dig, output int at, output bit ok);
    logic prev;
    logic cur;
    prev = sel_b ? ifb.rclk : ifa.rclk;
    ok = 1'b0;
    word = 16'h0; ld = 16'h0; dig = 3'd0; at = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cur = sel_b ? ifb.rclk : ifa.rclk;
      if (cur && !prev) begin
        ok   = 1'b1;
        word = sel_b ? sh_b : sh_a;
        ld   = sel_b ? ifb.line_data : ifa.line_data;
        dig  = sel_b ? ifb.line_counter : ifa.line_counter;
        at   = cyc;
        break;
      end
      prev = cur;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL latch_timeout dut=%0d got no rclk rise want one within 400 clks", sel_b);
    end
  endtask

  task automatic find_dig(input bit sel_b, input logic [2:0] target);
    logic [15:0] w, ld;
    logic [2:0]  d;
    int at;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      wait_latch(sel_b, w, ld, d, at, ok);
      if (!ok || d == target) break;
    end
  endtask

  task automatic pulse_update(input bit sel_b, input logic [31:0] v, input logic [7:0] d,
                              input logic [7:0] b);
    if (sel_b) begin
      ifb.value = v; ifb.dp = d; ifb.blank = b; ifb.update = 1'b1;
    end else begin
      ifa.value = v; ifa.dp = d; ifa.blank = b; ifa.update = 1'b1;
    end
    @(posedge clk); #1;
    ifa.update = 1'b0;
    ifb.update = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] w, ld;
    logic [2:0]  d;
    int at, at2, t0, first, width;
    bit ok;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (ifa.sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b want 0", ifa.sclk); end
    checks++; if (ifa.rclk !== 1'b0) begin errors++; $display("FAIL rst_rclk got %b want 0", ifa.rclk); end
    checks++; if (ifa.serial_data !== 1'b0) begin errors++; $display("FAIL rst_sdata got %b want 0", ifa.serial_data); end
    checks++; if (ifa.line_data !== 16'h0) begin errors++; $display("FAIL rst_line_data got %h want 0000", ifa.line_data); end
    checks++; if (ifa.s_counter !== 5'd0) begin errors++; $display("FAIL rst_s_counter got %0d want 0", ifa.s_counter); end
    checks++; if (ifa.line_counter !== 3'd0) begin errors++; $display("FAIL rst_line_counter got %0d want 0", ifa.line_counter); end

    rst_n_a = 1'b1; rst_n_b = 1'b1;
    t0 = cyc;
    first = -1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ifa.sclk) begin first = cyc - t0; break; end
    end
    checks++; if (first != 4) begin errors++; $display("FAIL first_sclk got %0d want 4", first); end
    checks++; if (ifa.s_counter !== 5'd15) begin errors++; $display("FAIL first_s_counter got %0d want 15", ifa.s_counter); end
    checks++; if (ifa.line_data !== 16'hFF00) begin errors++; $display("FAIL first_line_data got %h want FF00", ifa.line_data); end

    wait_latch(1'b0, w, ld, d, at, ok);
    checks++; if (at - t0 != 66) begin errors++; $display("FAIL rclk_rise got %0d want 66", at - t0); end
    checks++; if (w !== 16'hFF00) begin errors++; $display("FAIL blank_word0 got %h want FF00", w); end
    checks++; if (d !== 3'd0) begin errors++; $display("FAIL blank_dig0 got %0d want 0", d); end

    width = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      width++;
      if (!ifa.rclk) break;
    end
    checks++; if (width != 2) begin errors++; $display("FAIL rclk_width got %0d want 2", width); end

    wait_latch(1'b0, w, ld, d, at2, ok);
    checks++; if (at2 - at != 68) begin errors++; $display("FAIL digit_period got %0d want 68", at2 - at); end
    for (int i = 1; i < 8; i++) begin
      if (i > 1) wait_latch(1'b0, w, ld, d, at, ok);
      checks++; if (w !== 16'hFF00 || d !== 3'(i)) begin
        errors++; $display("FAIL blank_frame dig %0d got %h/%0d want FF00/%0d", i, w, d, i);
      end
    end
  endtask

  task automatic test_dp_polarity();
    logic [15:0] w, ld, exp;
    logic [2:0]  d;
    int at;
    bit ok;
    pulse_update(1'b1, 32'hF000_0000, 8'h80, 8'h00);
    find_dig(1'b1, 3'd7);
    for (int i = 0; i < 8; i++) begin
      wait_latch(1'b1, w, ld, d, at, ok);
      exp = (i == 7) ? 16'hF180 : {8'h3F, 8'h01 << i};
      checks++; if (w !== exp || d !== 3'(i)) begin
        errors++; $display("FAIL dp_pol dig %0d got %h/%0d want %h/%0d", i, w, d, exp, i);
      end
    end
    wait_latch(1'b1, w, ld, d, at, ok);
    checks++; if (d !== 3'd0 || w !== 16'h3F01) begin
      errors++; $display("FAIL line_wrap got %h/%0d want 3F01/0", w, d);
    end
  endtask

  task automatic test_digit0();
    logic [15:0] w, ld, exp;
    logic [2:0]  d;
    int at;
    bit ok;
    pulse_update(1'b0, 32'h0000_0001, 8'h00, 8'h00);
    find_dig(1'b0, 3'd7);
    for (int i = 0; i < 8; i++) begin
      wait_latch(1'b0, w, ld, d, at, ok);
      exp = (i == 0) ? 16'hF901 : {8'hC0, 8'h01 << i};
      checks++; if (w !== exp || d !== 3'(i)) begin
        errors++; $display("FAIL digit_word dig %0d got %h/%0d want %h/%0d", i, w, d, exp, i);
      end
      if (i == 0) begin
        checks++; if (ld !== exp) begin errors++; $display("FAIL line_data_d0 got %h want %h", ld, exp); end
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [15:0] w, ld, exp;
    logic [15:0] nw [8];
    logic [2:0]  d;
    int at;
    bit ok;
    nw[0] = 16'h4001; nw[1] = 16'hF902; nw[2] = 16'hA404; nw[3] = 16'hB008;
    nw[4] = 16'h9910; nw[5] = 16'h9220; nw[6] = 16'h8240; nw[7] = 16'hFF00;
    find_dig(1'b0, 3'd2);
    pulse_update(1'b0, 32'h0000_0055, 8'h00, 8'h00);
    wait_latch(1'b0, w, ld, d, at, ok);
    checks++; if (w !== 16'hC008 || d !== 3'd3) begin
      errors++; $display("FAIL mid_old dig 3 got %h/%0d want C008/3", w, d);
    end
    pulse_update(1'b0, 32'h7654_3210, 8'h01, 8'h80);
    for (int i = 4; i < 8; i++) begin
      wait_latch(1'b0, w, ld, d, at, ok);
      exp = {8'hC0, 8'h01 << i};
      checks++; if (w !== exp || d !== 3'(i)) begin
        errors++; $display("FAIL mid_old dig %0d got %h/%0d want %h/%0d", i, w, d, exp, i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      wait_latch(1'b0, w, ld, d, at, ok);
      checks++; if (w !== nw[i] || d !== 3'(i)) begin
        errors++; $display("FAIL mid_new dig %0d got %h/%0d want %h/%0d", i, w, d, nw[i], i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w, ld;
    logic [2:0]  d;
    int at;
    bit ok;
    find_dig(1'b0, 3'd7);
    // digit-0 load happens 4 clks after the digit-7 rclk rise; update lands on that edge
    repeat (3) @(posedge clk); #1;
    pulse_update(1'b0, 32'h0000_00AB, 8'h00, 8'h00);
    wait_latch(1'b0, w, ld, d, at, ok);
    checks++; if (w !== 16'h8301 || d !== 3'd0) begin
      errors++; $display("FAIL same_cycle dig 0 got %h/%0d want 8301/0", w, d);
    end
    wait_latch(1'b0, w, ld, d, at, ok);
    checks++; if (w !== 16'h8802 || d !== 3'd1) begin
      errors++; $display("FAIL same_cycle dig 1 got %h/%0d want 8802/1", w, d);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] w, ld;
    logic [2:0]  d;
    int at, t0;
    bit ok;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(posedge clk); #1;
      if (ifa.line_counter == 3'd0 && ifa.s_counter == 5'd9 && ifa.sclk) begin found = 1'b1; break; end
    end
    checks++; if (!found || ifa.serial_data !== 1'b1) begin
      errors++; $display("FAIL pre_reset_bit9 got found=%0d sdata=%b want 1/1", found, ifa.serial_data);
    end
    rst_n_a = 1'b0;
    #1;
    checks++; if (ifa.sclk !== 1'b0 || ifa.rclk !== 1'b0 || ifa.serial_data !== 1'b0) begin
      errors++; $display("FAIL async_pins got %b%b%b want 000", ifa.sclk, ifa.rclk, ifa.serial_data);
    end
    checks++; if (ifa.line_data !== 16'h0 || ifa.s_counter !== 5'd0) begin
      errors++; $display("FAIL async_regs got %h/%0d want 0000/0", ifa.line_data, ifa.s_counter);
    end
    repeat (5) @(posedge clk); #1;
    rst_n_a = 1'b1;
    t0 = cyc;
    wait_latch(1'b0, w, ld, d, at, ok);
    checks++; if (at - t0 != 66) begin errors++; $display("FAIL restart_latch got %0d want 66", at - t0); end
    checks++; if (w !== 16'hFF00 || d !== 3'd0) begin
      errors++; $display("FAIL restart_word got %h/%0d want FF00/0", w, d);
    end
  endtask

  initial begin
    ifa.value = 32'h0; ifa.dp = 8'h00; ifa.blank = 8'h00; ifa.update = 1'b0;
    ifb.value = 32'h0; ifb.dp = 8'h00; ifb.blank = 8'h00; ifb.update = 1'b0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    test_reset();
    test_dp_polarity();
    test_digit0();
    test_mid_frame();
    test_back_to_back();
    test_async_reset();
    checks++; if (overlap != 0) begin errors++; $display("FAIL sclk_rclk_overlap got %0d want 0", overlap); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
